// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: load/store funct3 codes, the
// idle control code, access sizes, FSM states and small decode helpers.
package lsu_pkg;

    // Load funct3 codes as produced by the decoder on readcontrol.
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    // Store funct3 codes as produced by the decoder on writecontrol.
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    // Control code meaning "no access this instruction".
    localparam logic [2:0] CTRL_NONE = 3'd7;

    // Access size, taken from funct3[1:0].
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC1 = 2'd1,
        S_ACC2 = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic load_legal(input logic [2:0] f3);
        return f3 inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic store_legal(input logic [2:0] f3);
        return f3 inside {SB, SH, SW};
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit: byte-enable
// generation and store-data shifting across up to two words, plus load
// byte assembly and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] ld_result,
    output logic        crosses
);

    logic [7:0]  mask;
    logic [7:0]  be_wide;
    logic [63:0] st_wide;
    logic [63:0] ld_wide;
    logic [31:0] ld_raw;

    // Spread the access over an 8-lane window: lanes 0-3 are the first word, 4-7 the next.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        mask = 8'h0F;
        case (size)
            SZ_BYTE: mask = 8'h01;
            SZ_HALF: mask = 8'h03;
            default: mask = 8'h0F;
        endcase

        be_wide  = mask << off;
        st_wide  = {32'd0, st_data} << {off, 3'b000};
        be_lo    = be_wide[3:0];
        be_hi    = be_wide[7:4];
        wdata_lo = st_wide[31:0];
        wdata_hi = st_wide[63:32];
        crosses  = |be_wide[7:4];

        ld_wide  = {ld_hi, ld_lo} >> {off, 3'b000};
        ld_raw   = ld_wide[31:0];
        case (size)
            SZ_BYTE: ld_result = is_unsigned ? {24'd0, ld_raw[7:0]}
                                             : {{24{ld_raw[7]}}, ld_raw[7:0]};
            SZ_HALF: ld_result = is_unsigned ? {16'd0, ld_raw[15:0]}
                                             : {{16{ld_raw[15]}}, ld_raw[15:0]};
            default: ld_result = ld_raw;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the RV32I core and a word-wide req/ack data
// memory. Latches one load or store, runs one or two word transactions and
// stalls the core with busy until the one-cycle done pulse.
// Optional feature macro: LSU_MISALIGN_EN -- when defined, accesses crossing
// a word boundary are split into two transactions; otherwise any misaligned
// access completes immediately with fault and no memory access.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        readcontrol,
    input  logic [2:0]        writecontrol,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_EN
    localparam logic MISALIGN_EN = 1'b1;
`else
    localparam logic MISALIGN_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [31:0]       word0_q, word0_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              rd_active, wr_active, issue;
    logic [2:0]        sel_f3;
    logic              sel_illegal, sel_misaligned;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       ld_lo, ld_hi, ld_result, wdata_lo, wdata_hi;
    logic [3:0]        be_lo, be_hi;
    logic              crosses;

    assign rd_active = (readcontrol != CTRL_NONE);
    assign wr_active = (writecontrol != CTRL_NONE);
    assign issue     = rd_active || wr_active;
    // A store wins when both codes are active.
    assign sel_f3    = wr_active ? writecontrol : readcontrol;
    assign sel_illegal    = wr_active ? !store_legal(writecontrol) : !load_legal(readcontrol);
    assign sel_misaligned = !MISALIGN_EN && is_misaligned(sel_f3[1:0], addr[1:0]);

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    // The second word's lanes sit above the first word's in the alignment window.
    assign ld_lo = (state_q == S_ACC2) ? word0_q : mem_rdata;
    assign ld_hi = (state_q == S_ACC2) ? mem_rdata : 32'd0;

    lsu_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .off         (addr_q[1:0]),
        .st_data     (wdata_q),
        .ld_lo       (ld_lo),
        .ld_hi       (ld_hi),
        .be_lo       (be_lo),
        .be_hi       (be_hi),
        .wdata_lo    (wdata_lo),
        .wdata_hi    (wdata_hi),
        .ld_result   (ld_result),
        .crosses     (crosses)
    );

    // Next-state logic: latch the instruction on issue, advance on mem_ack.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fault_d    = fault_q;
        word0_d    = word0_q;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    is_store_d = wr_active;
                    size_d     = sel_f3[1:0];
                    uns_d      = sel_f3[2];
                    addr_d     = addr;
                    wdata_d    = wdata;
                    fault_d    = (rd_active && wr_active) || sel_illegal || sel_misaligned;
                    state_d    = (sel_illegal || sel_misaligned) ? S_DONE : S_ACC1;
                end
            end
            S_ACC1: begin
                if (mem_ack) begin
                    if (MISALIGN_EN && crosses) begin
                        word0_d = mem_rdata;
                        state_d = S_ACC2;
                    end else begin
                        state_d = S_DONE;
                        if (!is_store_q) rdata_d = ld_result;
                    end
                end
            end
            S_ACC2: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    if (!is_store_q) rdata_d = ld_result;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            fault_q    <= 1'b0;
            word0_q    <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fault_q    <= fault_d;
            word0_q    <= word0_d;
            rdata_q    <= rdata_d;
        end
    end

    // Core-side handshake and memory port, all derived from the registered state.
    always_comb begin
        mem_req   = (state_q == S_ACC1) || (state_q == S_ACC2);
        mem_we    = mem_req && is_store_q;
        mem_addr  = '0;
        mem_be    = 4'd0;
        mem_wdata = 32'd0;
        if (state_q == S_ACC1) begin
            mem_addr  = word_addr;
            mem_be    = be_lo;
            mem_wdata = is_store_q ? wdata_lo : 32'd0;
        end else if (state_q == S_ACC2) begin
            mem_addr  = word_addr + ADDR_W'(4);
            mem_be    = be_hi;
            mem_wdata = is_store_q ? wdata_hi : 32'd0;
        end
        busy  = ((state_q == S_IDLE) && issue) || mem_req;
        done  = (state_q == S_DONE);
        fault = done && fault_q;
        rdata = rdata_q;
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected memory transactions and
// completions into queues; monitors pop and compare when the DUT presents a
// handshake or a done pulse. Expected values for crossing accesses follow
// LSU_MISALIGN_EN as compiled.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  readcontrol, writecontrol;
    logic [31:0] addr, wdata, rdata;
    logic        busy, done, fault;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .readcontrol(readcontrol), .writecontrol(writecontrol),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; logic fault; int issue_cyc; int lat; } done_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } txn_t;

    done_exp_t   done_q[$];
    txn_t        txn_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_wait = 0;
    int          wait_cnt = 0;
    logic [31:0] model_rdata = 32'd0;
    txn_t        mt;
    done_exp_t   de;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic we, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd);
        txn_t t;
        t.we = we; t.addr = a; t.be = be; t.wdata = wd;
        txn_q.push_back(t);
    endtask

    // Drive one instruction at the next falling edge and hold it until done.
    task automatic do_op(input string name, input logic [2:0] rc, input logic [2:0] wc,
                         input logic [31:0] a, input logic [31:0] wd, input int wait_c,
                         input logic [31:0] exp_rd, input logic exp_fault, input int lat);
        done_exp_t e;
        bit seen = 1'b0;
        @(negedge clk);
        mem_wait = wait_c;
        readcontrol = rc; writecontrol = wc; addr = a; wdata = wd;
        e.rdata = exp_rd; e.fault = exp_fault; e.issue_cyc = cyc; e.lat = lat;
        done_q.push_back(e);
        for (int i = 0; i < 20 && !seen; i++) begin
            #3;
            if (done) begin
                seen = 1'b1;
                check({name, "_busy_at_done"}, busy, 0);
            end else begin
                check({name, "_busy_while_pending"}, busy, 1);
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
        end
        model_rdata = exp_rd;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        readcontrol = CTRL_NONE; writecontrol = CTRL_NONE;
        repeat (n - 1) @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: acks after mem_wait stall cycles, returns queued read words.
    initial begin
        mem_ack = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wait_cnt >= mem_wait) begin
                    mem_ack = 1'b1;
                    wait_cnt = 0;
                    if (!mem_we) mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_DEAD;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: compare every completed memory handshake and every done pulse.
    initial forever begin
        @(negedge clk);
        #2;
        if (mem_req && mem_ack) begin
            if (txn_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_txn: got addr 0x%0h we %0d expected no transaction",
                         mem_addr, mem_we);
            end else begin
                mt = txn_q.pop_front();
                check("txn_we", mem_we, mt.we);
                check("txn_addr", mem_addr, mt.addr);
                check("txn_be", mem_be, mt.be);
                if (mt.we) check("txn_wdata", mem_wdata, mt.wdata);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0");
            end else begin
                de = done_q.pop_front();
                check("done_rdata", rdata, de.rdata);
                check("done_fault", fault, de.fault);
                check("done_latency", cyc - de.issue_cyc, de.lat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        readcontrol = CTRL_NONE; writecontrol = CTRL_NONE; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset_rdata", rdata, 0);
        check("reset_ctrl", {busy, done, fault, mem_req, mem_we, mem_be}, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);

        // Aligned store, zero-wait memory.
        push_txn(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        do_op("sw_aligned", CTRL_NONE, SW, 32'h100, 32'hDEADBEEF, 0, model_rdata, 1'b0, 2);
        idle(1);

        // Signed then unsigned byte load, issued back-to-back.
        push_txn(1'b0, 32'h100, 4'h8, 32'h0); rd_q.push_back(32'h80FFFFFF);
        do_op("lb_neg", LB, CTRL_NONE, 32'h103, 32'h0, 0, 32'hFFFFFF80, 1'b0, 2);
        push_txn(1'b0, 32'h100, 4'h8, 32'h0); rd_q.push_back(32'h80FFFFFF);
        do_op("lbu", LBU, CTRL_NONE, 32'h103, 32'h0, 0, 32'h00000080, 1'b0, 2);
        idle(1);

        // Sub-word stores land in the right lanes.
        push_txn(1'b1, 32'h100, 4'h2, 32'h3456A500);
        do_op("sb_off1", CTRL_NONE, SB, 32'h101, 32'h123456A5, 0, model_rdata, 1'b0, 2);
        idle(1);
        push_txn(1'b1, 32'h100, 4'hC, 32'hCAFE0000);
        do_op("sh_off2", CTRL_NONE, SH, 32'h102, 32'h1234CAFE, 0, model_rdata, 1'b0, 2);
        idle(1);

        // Halfword loads from the upper half.
        push_txn(1'b0, 32'h100, 4'hC, 32'h0); rd_q.push_back(32'h80017777);
        do_op("lh_neg", LH, CTRL_NONE, 32'h102, 32'h0, 0, 32'hFFFF8001, 1'b0, 2);
        idle(1);
        push_txn(1'b0, 32'h100, 4'hC, 32'h0); rd_q.push_back(32'h80017777);
        do_op("lhu", LHU, CTRL_NONE, 32'h102, 32'h0, 0, 32'h00008001, 1'b0, 2);
        idle(1);

        // Word-boundary crossing accesses.
`ifdef LSU_MISALIGN_EN
        push_txn(1'b0, 32'h100, 4'hC, 32'h0); push_txn(1'b0, 32'h104, 4'h3, 32'h0);
        rd_q.push_back(32'hAAAA1111); rd_q.push_back(32'h2222BBBB);
        do_op("lw_cross", LW, CTRL_NONE, 32'h102, 32'h0, 0, 32'hBBBBAAAA, 1'b0, 3);
        idle(1);
        push_txn(1'b1, 32'h104, 4'h8, 32'h44000000); push_txn(1'b1, 32'h108, 4'h7, 32'h00112233);
        do_op("sw_cross", CTRL_NONE, SW, 32'h107, 32'h11223344, 0, model_rdata, 1'b0, 3);
        idle(1);
        push_txn(1'b0, 32'h108, 4'h8, 32'h0); push_txn(1'b0, 32'h10C, 4'h1, 32'h0);
        rd_q.push_back(32'hAB000000); rd_q.push_back(32'h000000CD);
        do_op("lh_cross", LH, CTRL_NONE, 32'h10B, 32'h0, 0, 32'hFFFFCDAB, 1'b0, 3);
        idle(1);
`else
        do_op("lw_misalign", LW, CTRL_NONE, 32'h102, 32'h0, 0, model_rdata, 1'b1, 1);
        idle(1);
        do_op("sw_misalign", CTRL_NONE, SW, 32'h107, 32'h11223344, 0, model_rdata, 1'b1, 1);
        idle(1);
        do_op("lh_misalign", LH, CTRL_NONE, 32'h10B, 32'h0, 0, model_rdata, 1'b1, 1);
        idle(1);
`endif

        // Illegal codes fault without touching memory.
        do_op("illegal_read", 3'd3, CTRL_NONE, 32'h100, 32'h0, 0, model_rdata, 1'b1, 1);
        idle(1);
        do_op("illegal_write", CTRL_NONE, 3'd5, 32'h100, 32'h0, 0, model_rdata, 1'b1, 1);
        idle(1);

        // Load and store together: store performed, fault flagged.
        push_txn(1'b1, 32'h108, 4'hF, 32'h55AA55AA);
        do_op("both_active", LW, SW, 32'h108, 32'h55AA55AA, 0, model_rdata, 1'b1, 2);
        idle(1);

        // Three memory wait states stretch the access by three cycles.
        push_txn(1'b0, 32'h200, 4'hF, 32'h0); rd_q.push_back(32'h12345678);
        do_op("lw_wait3", LW, CTRL_NONE, 32'h200, 32'h0, 3, 32'h12345678, 1'b0, 5);
        idle(1);

        // Reset in ACC1 on the same cycle the ack arrives: no done, bus released.
        @(negedge clk);
        mem_wait = 1;
        push_txn(1'b0, 32'h300, 4'hF, 32'h0); rd_q.push_back(32'h0BAD0BAD);
        readcontrol = LW; addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; readcontrol = CTRL_NONE; writecontrol = CTRL_NONE;
        @(negedge clk);
        #3;
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_rdata", rdata, 0);
        rst = 1'b0;
        model_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            check("rst_no_done", done, 0);
        end

        // Normal operation resumes after the mid-transaction reset.
        push_txn(1'b0, 32'h304, 4'hF, 32'h0); rd_q.push_back(32'hCAFEF00D);
        do_op("lw_after_rst", LW, CTRL_NONE, 32'h304, 32'h0, 0, 32'hCAFEF00D, 1'b0, 2);
        idle(3);

        check("txn_queue_empty", txn_q.size(), 0);
        check("done_queue_empty", done_q.size(), 0);
        check("rd_queue_empty", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
